// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer in front of a single-port data memory.
// Each grant runs ACCESS (controls held one full cycle) then RESP (one-cycle ack).

module dmem_arb_port #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              done_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              ack_o,
    output logic [DATA_W-1:0] rdata_o
);
    logic              ack_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= done_i;
            // stores leave the previous load result in place
            if (done_i && load_i) rdata_q <= mem_rdata_i;
        end
    end

    assign ack_o   = ack_q;
    assign rdata_o = rdata_q;
endmodule

module dmem_arbiter #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] rdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ack1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                             state_q;
    logic                               last_q;
    logic                               win_q;
    logic                               we_q;
    logic [ADDR_W-1:0]                  mem_addr_q;
    logic [DATA_W-1:0]                  mem_wdata_q;
    logic                               mem_read_q;
    logic                               mem_write_q;
    logic                               busy_q;

    logic [NUM_PORTS-1:0]               req_v;
    logic [NUM_PORTS-1:0]               we_v;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]   addr_v;
    logic [NUM_PORTS-1:0][DATA_W-1:0]   wdata_v;
    logic [NUM_PORTS-1:0]               ack_v;
    logic [NUM_PORTS-1:0][DATA_W-1:0]   rdata_v;

    logic [NUM_PORTS-1:0]               elig_d;
    logic                               sel_d;
    logic                               grant_d;

    assign req_v   = {req1, req0};
    assign we_v    = {we1, we0};
    assign addr_v  = {addr1, addr0};
    assign wdata_v = {wdata1, wdata0};

    // The port served in RESP is masked: its req is allowed to still be high.
    always_comb begin
        elig_d = req_v;
        if (state_q == ACCESS)
            elig_d = '0;
        else if (state_q == RESP)
            elig_d[win_q] = 1'b0;
        if (elig_d == 2'b11)
            sel_d = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_q;
        else
            sel_d = elig_d[1];
    end

    assign grant_d = |elig_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            win_q       <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, RESP: begin
                    if (grant_d) begin
                        state_q     <= ACCESS;
                        win_q       <= sel_d;
                        we_q        <= we_v[sel_d];
                        mem_addr_q  <= addr_v[sel_d];
                        mem_wdata_q <= wdata_v[sel_d];
                        mem_read_q  <= ~we_v[sel_d];
                        mem_write_q <= we_v[sel_d];
                        busy_q      <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ACCESS: begin
                    state_q     <= RESP;
                    last_q      <= win_q;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    busy_q      <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    genvar p;
    generate
        for (p = 0; p < NUM_PORTS; p++) begin : g_port
            dmem_arb_port #(.DATA_W(DATA_W)) u_port (
                .clk         (clk),
                .reset       (reset),
                .done_i      ((state_q == ACCESS) && (win_q == 1'(p))),
                .load_i      (~we_q),
                .mem_rdata_i (mem_rdata),
                .ack_o       (ack_v[p]),
                .rdata_o     (rdata_v[p])
            );
        end
    endgenerate

    assign ack0      = ack_v[0];
    assign ack1      = ack_v[1];
    assign rdata0    = rdata_v[0];
    assign rdata1    = rdata_v[1];
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin instance checked each cycle against a
// transaction-level model, plus a fixed-priority instance for the tie case.

module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]       req_d, we_d;
    logic [1:0][7:0]  addr_d;
    logic [1:0][31:0] wdata_d;

    logic [1:0]       ack_a, ack_b;
    logic [1:0][31:0] rd_a, rd_b;
    logic [7:0]       maddr_a, maddr_b;
    logic [31:0]      mwdata_a, mwdata_b, mrdata_a, mrdata_b;
    logic             mread_a, mwrite_a, busy_a, mread_b, mwrite_b, busy_b;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] ref_mem [256];

    assign mrdata_a = mem_a[maddr_a];
    assign mrdata_b = mem_b[maddr_b];
    always @(negedge clk) if (mwrite_a) mem_a[maddr_a] <= mwdata_a;
    always @(negedge clk) if (mwrite_b) mem_b[maddr_b] <= mwdata_b;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .FIXED_PRIORITY(0)) u_rr (
        .clk(clk), .reset(reset),
        .req0(req_d[0]), .we0(we_d[0]), .addr0(addr_d[0]), .wdata0(wdata_d[0]),
        .rdata0(rd_a[0]), .ack0(ack_a[0]),
        .req1(req_d[1]), .we1(we_d[1]), .addr1(addr_d[1]), .wdata1(wdata_d[1]),
        .rdata1(rd_a[1]), .ack1(ack_a[1]),
        .mem_addr(maddr_a), .mem_wdata(mwdata_a), .mem_read(mread_a),
        .mem_write(mwrite_a), .mem_rdata(mrdata_a), .busy(busy_a));

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .FIXED_PRIORITY(1)) u_fx (
        .clk(clk), .reset(reset),
        .req0(req_d[0]), .we0(we_d[0]), .addr0(addr_d[0]), .wdata0(wdata_d[0]),
        .rdata0(rd_b[0]), .ack0(ack_b[0]),
        .req1(req_d[1]), .we1(we_d[1]), .addr1(addr_d[1]), .wdata1(wdata_d[1]),
        .rdata1(rd_b[1]), .ack1(ack_b[1]),
        .mem_addr(maddr_b), .mem_wdata(mwdata_b), .mem_read(mread_b),
        .mem_write(mwrite_b), .mem_rdata(mrdata_b), .busy(busy_b));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction model: a grant occupies one access cycle, then a response cycle.
    bit               m_init = 0;
    int               m_age  = 0;   // 0 idle, 1 access cycle, 2 response cycle
    int               m_srv  = 0;
    int               m_last = 1;
    int               m_w;
    logic [1:0]       m_elig;
    logic [1:0]       m_ack  = '0;
    logic [1:0][31:0] m_rd   = '0;
    logic             m_read = 0, m_write = 0, m_we = 0;
    logic [7:0]       m_addr = '0;
    logic [31:0]      m_wdata = '0;

    always @(posedge clk) begin
        if (m_age == 1 && m_we) ref_mem[m_addr] = m_wdata;
        if (reset) begin
            m_init = 1; m_age = 0; m_srv = 0; m_last = 1; m_ack = '0; m_rd = '0;
            m_read = 0; m_write = 0; m_we = 0; m_addr = '0; m_wdata = '0;
        end else begin
            m_ack = '0;
            if (m_age == 1) begin
                if (!m_we) m_rd[m_srv] = ref_mem[m_addr];
                m_ack[m_srv] = 1'b1;
                m_last = m_srv; m_read = 0; m_write = 0; m_age = 2;
            end else begin
                m_elig = req_d;
                if (m_age == 2) m_elig[m_srv] = 1'b0;
                if (m_elig == 2'b00) m_age = 0;
                else begin
                    if (m_elig == 2'b11) m_w = 1 - m_last;
                    else m_w = m_elig[1] ? 1 : 0;
                    m_srv = m_w; m_we = we_d[m_w]; m_addr = addr_d[m_w];
                    m_wdata = wdata_d[m_w]; m_read = !we_d[m_w]; m_write = we_d[m_w];
                    m_age = 1;
                end
            end
        end
    end

    always @(negedge clk) if (m_init) begin
        check("ack0", ack_a[0], m_ack[0]);
        check("ack1", ack_a[1], m_ack[1]);
        check("rdata0", rd_a[0], m_rd[0]);
        check("rdata1", rd_a[1], m_rd[1]);
        check("mem_read", mread_a, m_read);
        check("mem_write", mwrite_a, m_write);
        check("mem_addr", maddr_a, m_addr);
        check("mem_wdata", mwdata_a, m_wdata);
        check("busy", busy_a, m_age != 0);
    end

    int cyc = 0, wr_cnt = 0, rd_cnt = 0, act_cnt = 0, ack1_cnt = 0, both_cnt = 0;
    logic [7:0] last_rd_addr = '0;
    int qa[$], qa_cyc[$], qb[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mwrite_a) wr_cnt++;
        if (mread_a) begin rd_cnt++; last_rd_addr = maddr_a; end
        if (mread_a || mwrite_a || busy_a) act_cnt++;
        if (ack_a[1]) ack1_cnt++;
        if (ack_a[0] && ack_a[1]) both_cnt++;
        if (ack_a[0]) begin qa.push_back(0); qa_cyc.push_back(cyc); end
        if (ack_a[1]) begin qa.push_back(1); qa_cyc.push_back(cyc); end
        if (ack_b[0]) qb.push_back(0);
        if (ack_b[1]) qb.push_back(1);
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Raise an op on port p and hold it until its ack; returns in the ack cycle.
    task automatic port_op(input int p, input bit we, input logic [7:0] a,
                           input logic [31:0] d, output int lat);
        bit got;
        req_d[p] = 1'b1; we_d[p] = we; addr_d[p] = a; wdata_d[p] = d;
        lat = 0; got = 0;
        while (!got && lat < 50) begin
            step();
            lat++;
            got = ack_a[p];
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout port=%0d actual=no_ack required=ack", p);
        end
    endtask

    task automatic release_port(input int p);
        step();
        req_d[p] = 1'b0;
    endtask

    int lat, l0, l1, base, w0, r0, a0, k1, b0, qbase;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0; mem_b[i] = '0; ref_mem[i] = '0;
        end
        reset = 1'b1; req_d = '0; we_d = '0; addr_d = '0; wdata_d = '0;
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        check("rst_busy", busy_a, 0);
        check("rst_ack", ack_a, 0);
        check("rst_mem_rw", {mread_a, mwrite_a}, 0);
        check("rst_mem_addr", maddr_a, 0);

        // single store then load on port 0
        w0 = wr_cnt; r0 = rd_cnt;
        port_op(0, 1'b1, 8'h10, 32'hDEADBEEF, lat);
        check("store_latency", lat, 2);
        release_port(0); idle(2);
        check("store_write_cycles", wr_cnt - w0, 1);
        port_op(0, 1'b0, 8'h10, 32'h0, lat);
        check("load_latency", lat, 2);
        check("load_rdata0", rd_a[0], 32'hDEADBEEF);
        check("load_read_cycles", rd_cnt - r0, 1);
        release_port(0); idle(2);

        // round-robin tie straight after reset: 0,1,0,1 every 2 cycles
        reset = 1'b1; step(); reset = 1'b0;
        base = qa.size(); b0 = both_cnt;
        fork
            begin port_op(0, 1'b0, 8'h10, 32'h0, l0); step();
                  port_op(0, 1'b0, 8'h10, 32'h0, l0); release_port(0); end
            begin port_op(1, 1'b0, 8'h10, 32'h0, l1); step();
                  port_op(1, 1'b0, 8'h10, 32'h0, l1); release_port(1); end
        join
        idle(2);
        check("rr_ack_count", qa.size() - base, 4);
        if (qa.size() - base == 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), qa[base+i], i % 2);
            for (int i = 0; i < 3; i++)
                check($sformatf("rr_gap%0d", i), qa_cyc[base+i+1] - qa_cyc[base+i], 2);
        end
        check("rr_no_dual_ack", both_cnt - b0, 0);
        check("rr_rdata1", rd_a[1], 32'hDEADBEEF);

        // tie after port 0 was served last: RR picks 1, fixed picks 0
        port_op(0, 1'b0, 8'h10, 32'h0, lat); release_port(0); idle(2);
        base = qa.size(); qbase = qb.size();
        fork
            begin port_op(0, 1'b0, 8'h10, 32'h0, l0); release_port(0); end
            begin port_op(1, 1'b0, 8'h10, 32'h0, l1); release_port(1); end
        join
        idle(2);
        check("rr_tie_first", (qa.size() > base) ? qa[base] : 9, 1);
        check("fx_tie_first", (qb.size() > qbase) ? qb[qbase] : 9, 0);
        check("fx_tie_second", (qb.size() > qbase + 1) ? qb[qbase+1] : 9, 1);

        // reset lands on the posedge that closes a port 1 store's access cycle
        k1 = ack1_cnt;
        req_d[1] = 1'b1; we_d[1] = 1'b1; addr_d[1] = 8'h05; wdata_d[1] = 32'h1234;
        step();
        reset = 1'b1;
        step();
        req_d[1] = 1'b0; we_d[1] = 1'b0; reset = 1'b0;
        check("rstmid_ack", ack_a, 0);
        check("rstmid_rdata", {rd_a[0] | rd_a[1]}, 0);
        check("rstmid_mem", {mread_a, mwrite_a, busy_a}, 0);
        check("rstmid_addr", {maddr_a, 24'h0} | mwdata_a, 0);
        idle(3);
        check("rstmid_no_ack1", ack1_cnt - k1, 0);
        check("rstmid_mem5", mem_a[5], 32'h1234);

        // address boundaries
        port_op(0, 1'b1, 8'hFF, 32'hA5A55A5A, lat); release_port(0); idle(1);
        port_op(0, 1'b1, 8'h00, 32'h13579BDF, lat); release_port(0); idle(1);
        port_op(0, 1'b0, 8'h00, 32'h0, lat);
        check("bnd_rdata0", rd_a[0], 32'h13579BDF);
        check("bnd_addr00", last_rd_addr, 8'h00);
        release_port(0); idle(1);
        port_op(1, 1'b0, 8'hFF, 32'h0, lat);
        check("bnd_rdata1", rd_a[1], 32'hA5A55A5A);
        check("bnd_addrFF", last_rd_addr, 8'hFF);
        release_port(1); idle(2);

        // idle hold
        a0 = act_cnt;
        idle(10);
        check("idle_activity", act_cnt - a0, 0);
        check("idle_rdata0", rd_a[0], 32'h13579BDF);
        check("idle_rdata1", rd_a[1], 32'hA5A55A5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
